// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: multiplexed common-anode hex display driver.
// Scans digits most-significant first, with per-digit enable, leading-zero
// blanking, PWM brightness, a dark gap at the start of every slot and
// frame-coherent capture of all display inputs.
module seven_seg_scanner #(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 8192,
  parameter int BRIGHT_W   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lz_blank,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic [6:0]              seg,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);

  localparam int PRE_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DUTY_SHIFT = PRE_W - BRIGHT_W;

  localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  // Scan position
  logic [PRE_W-1:0] pre_q;
  logic [IDX_W-1:0] idx_q;

  // Shadow copies of the inputs, refreshed once per frame
  logic [4*NUM_DIGITS-1:0] data_sh;
  logic [NUM_DIGITS-1:0]   dp_sh;
  logic [NUM_DIGITS-1:0]   en_sh;
  logic                    lz_sh;
  logic [BRIGHT_W-1:0]     bright_sh;

  // Values actually used for decode in the current cycle
  logic                    frame_cycle;
  logic [4*NUM_DIGITS-1:0] data_cur;
  logic [NUM_DIGITS-1:0]   dp_cur;
  logic [NUM_DIGITS-1:0]   en_cur;
  logic                    lz_cur;
  logic [BRIGHT_W-1:0]     bright_cur;

  logic [NUM_DIGITS-1:0]   zero_run;
  logic                    run_acc;
  logic [3:0]              nibble;
  logic                    zero_blank;
  logic                    duty_ok;
  logic                    drive;
  logic [6:0]              pattern;

  // Hex nibble to active-low {g,f,e,d,c,b,a} segment pattern
  function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
    logic [6:0] result;
    case (value)
      4'h0:    result = 7'b1000000;
      4'h1:    result = 7'b1111001;
      4'h2:    result = 7'b0100100;
      4'h3:    result = 7'b0110000;
      4'h4:    result = 7'b0011001;
      4'h5:    result = 7'b0010010;
      4'h6:    result = 7'b0000010;
      4'h7:    result = 7'b1111000;
      4'h8:    result = 7'b0000000;
      4'h9:    result = 7'b0010000;
      4'hA:    result = 7'b0001000;
      4'hB:    result = 7'b0000011;
      4'hC:    result = 7'b1000110;
      4'hD:    result = 7'b0100001;
      4'hE:    result = 7'b0000110;
      default: result = 7'b0001110;
    endcase
    return result;
  endfunction

  // The frame-start cycle decodes straight from the live inputs so the new
  // frame's first slot already shows the values being captured
  always_comb begin
    frame_cycle = (pre_q == '0) && (idx_q == LAST_IDX);
    data_cur    = frame_cycle ? data       : data_sh;
    dp_cur      = frame_cycle ? dp         : dp_sh;
    en_cur      = frame_cycle ? digit_en   : en_sh;
    lz_cur      = frame_cycle ? lz_blank   : lz_sh;
    bright_cur  = frame_cycle ? brightness : bright_sh;
  end

  // zero_run[i] is set when every nibble from the leftmost digit down to i is zero
  always_comb begin
    run_acc  = 1'b1;
    zero_run = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run_acc     = run_acc & (data_cur[4*i +: 4] == 4'h0);
      zero_run[i] = run_acc;
    end
  end

  // Decide whether the current digit is lit and what it shows
  always_comb begin
    nibble     = data_cur[{idx_q, 2'b00} +: 4];
    zero_blank = lz_cur && (idx_q != '0) && zero_run[idx_q];
    duty_ok    = (pre_q >> DUTY_SHIFT) <= PRE_W'(bright_cur);
    drive      = en_cur[idx_q] && !zero_blank && (pre_q != '0) && duty_ok;
    pattern    = hex_to_seg(nibble);
  end

  // Prescaler, digit index and once-per-frame shadow capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q     <= '0;
      idx_q     <= LAST_IDX;
      data_sh   <= '0;
      dp_sh     <= '0;
      en_sh     <= '0;
      lz_sh     <= 1'b0;
      bright_sh <= '0;
    end else begin
      if (pre_q == PRE_MAX) begin
        pre_q <= '0;
        idx_q <= (idx_q == '0) ? LAST_IDX : idx_q - IDX_W'(1);
      end else begin
        pre_q <= pre_q + PRE_W'(1);
      end
      if (frame_cycle) begin
        data_sh   <= data;
        dp_sh     <= dp;
        en_sh     <= digit_en;
        lz_sh     <= lz_blank;
        bright_sh <= brightness;
      end
    end
  end

  // Registered pin drivers; a dark digit releases every cathode and anode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an          <= '1;
      seg         <= 7'h7F;
      dp_n        <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_cycle;
      if (drive) begin
        an   <= ~(NUM_DIGITS'(1) << idx_q);
        seg  <= pattern;
        dp_n <= ~dp_cur[idx_q];
      end else begin
        an   <= '1;
        seg  <= 7'h7F;
        dp_n <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: randomized self-checking bench for seven_seg_scanner.
// A frame-level model predicts every output cycle; literal checks pin the
// model to hand-computed values for the documented scenarios.
module tb_seven_seg_scanner;

  localparam int ND = 4;
  localparam int SD = 16;
  localparam int BW = 2;
  localparam int FRAME = ND * SD;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [15:0]   data;
  logic [3:0]    dp;
  logic [3:0]    digit_en;
  logic          lz_blank;
  logic [1:0]    brightness;
  logic [6:0]    seg;
  logic          dp_n;
  logic [3:0]    an;
  logic          frame_start;

  int check_count = 0;
  int pass_count  = 0;

  seven_seg_scanner #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BRIGHT_W(BW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data        (data),
    .dp          (dp),
    .digit_en    (digit_en),
    .lz_blank    (lz_blank),
    .brightness  (brightness),
    .seg         (seg),
    .dp_n        (dp_n),
    .an          (an),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model state: cycle count since reset and the inputs latched for this frame
  int         n_cycles = 0;
  int         last_pos = -1;
  int         m_pos, m_digit, m_pre;
  logic       m_blank, m_on;
  logic [15:0] f_data = '0;
  logic [3:0]  f_dp = '0, f_en = '0;
  logic        f_lz = 1'b0;
  logic [1:0]  f_br = '0;
  logic [3:0]  exp_an  = 4'hF;
  logic [6:0]  exp_seg = 7'h7F;
  logic        exp_dpn = 1'b1;
  logic        exp_fs  = 1'b0;

  task automatic check_val(input string name, input logic [15:0] got, input logic [15:0] want);
    check_count++;
    if (got === want) pass_count++;
    else $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, got, want, $time);
  endtask

  task automatic check_output(input string name, input logic [3:0] want_an,
                              input logic [6:0] want_seg, input logic want_dpn);
    check_val({name, ".an"}, 16'(an), 16'(want_an));
    check_val({name, ".seg"}, 16'(seg), 16'(want_seg));
    check_val({name, ".dp_n"}, 16'(dp_n), 16'(want_dpn));
  endtask

  // Wait (bounded) until the outputs on display belong to frame position p
  task automatic wait_pos(input int p);
    bit found = 1'b0;
    for (int k = 0; k < 3 * FRAME && !found; k++) begin
      @(negedge clk);
      if (last_pos == p) found = 1'b1;
    end
    if (!found) check_val("wait_pos_timeout", 16'(last_pos), 16'(p));
  endtask

  task automatic apply_stimulus();
    data = 16'($urandom);
    if ($urandom_range(0, 1) == 1) data = data & (16'hFFFF >> (4 * $urandom_range(1, 4)));
    dp         = 4'($urandom);
    digit_en   = 4'($urandom);
    lz_blank   = 1'($urandom);
    brightness = 2'($urandom);
  endtask

  // Behavioural model: frame position gives digit and prescaler directly
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_cycles = 0;
      last_pos = -1;
      f_data = '0; f_dp = '0; f_en = '0; f_lz = 1'b0; f_br = '0;
      exp_an = 4'hF; exp_seg = 7'h7F; exp_dpn = 1'b1; exp_fs = 1'b0;
    end else begin
      m_pos   = n_cycles % FRAME;
      m_digit = ND - 1 - m_pos / SD;
      m_pre   = m_pos % SD;
      if (m_pos == 0) begin
        f_data = data; f_dp = dp; f_en = digit_en; f_lz = lz_blank; f_br = brightness;
      end
      m_blank = f_lz && (m_digit != 0) && ((f_data >> (4 * m_digit)) == 16'h0);
      m_on    = f_en[m_digit] && !m_blank && (m_pre != 0) && (m_pre < (int'(f_br) + 1) * SD / 4);
      if (m_on) begin
        exp_an  = ~(4'b0001 << m_digit);
        exp_seg = hex_tab[f_data[4*m_digit +: 4]];
        exp_dpn = ~f_dp[m_digit];
      end else begin
        exp_an = 4'hF; exp_seg = 7'h7F; exp_dpn = 1'b1;
      end
      exp_fs   = (m_pos == 0);
      last_pos = m_pos;
      n_cycles++;
    end
  end

  // Compare every output against the model on each falling edge
  always @(negedge clk) begin
    check_val("model.an", 16'(an), 16'(exp_an));
    check_val("model.seg", 16'(seg), 16'(exp_seg));
    check_val("model.dp_n", 16'(dp_n), 16'(exp_dpn));
    check_val("model.frame_start", 16'(frame_start), 16'(exp_fs));
  end

  initial begin
    data = 16'h1234; dp = 4'h0; digit_en = 4'hF; lz_blank = 1'b0; brightness = 2'd3;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_output("reset", 4'hF, 7'h7F, 1'b1);
    check_val("reset.frame_start", 16'(frame_start), 16'h0);

    // Scan after release: dark gap with frame pulse, then digits 3..0
    rst_n = 1'b1;
    @(negedge clk);
    check_val("first.frame_start", 16'(frame_start), 16'h1);
    check_output("first_gap", 4'hF, 7'h7F, 1'b1);
    @(negedge clk);
    check_output("scan_d3", 4'b0111, 7'h79, 1'b1);
    repeat (16) @(negedge clk);
    check_output("scan_d2", 4'b1011, 7'h24, 1'b1);

    // Frame coherence: change data inside the digit-2 slot
    data = 16'hABCD;
    repeat (16) @(negedge clk);
    check_output("coherent_d1_old", 4'b1101, 7'h30, 1'b1);
    repeat (32) @(negedge clk);
    check_output("coherent_d3_new", 4'b0111, 7'h08, 1'b1);
    repeat (16) @(negedge clk);
    check_output("coherent_d2_new", 4'b1011, 7'h03, 1'b1);

    // Leading-zero blanking
    lz_blank = 1'b1; data = 16'h0050;
    wait_pos(0);
    wait_pos(1);  check_output("lz_d3", 4'hF, 7'h7F, 1'b1);
    wait_pos(17); check_output("lz_d2", 4'hF, 7'h7F, 1'b1);
    wait_pos(33); check_output("lz_d1", 4'b1101, 7'h12, 1'b1);
    wait_pos(49); check_output("lz_d0", 4'b1110, 7'h40, 1'b1);
    data = 16'h0000;
    wait_pos(0);
    wait_pos(33); check_output("lz0_d1", 4'hF, 7'h7F, 1'b1);
    wait_pos(49); check_output("lz0_d0", 4'b1110, 7'h40, 1'b1);

    // Brightness duty
    lz_blank = 1'b0; data = 16'h1234; brightness = 2'd0;
    wait_pos(0);
    wait_pos(3); check_output("br0_on", 4'b0111, 7'h79, 1'b1);
    wait_pos(4); check_output("br0_off", 4'hF, 7'h7F, 1'b1);
    brightness = 2'd1;
    wait_pos(0);
    wait_pos(7); check_output("br1_on", 4'b0111, 7'h79, 1'b1);
    wait_pos(8); check_output("br1_off", 4'hF, 7'h7F, 1'b1);

    // Per-digit enable and decimal point
    brightness = 2'd3; digit_en = 4'b1010; dp = 4'b0010;
    wait_pos(0);
    wait_pos(17); check_output("en_d2", 4'hF, 7'h7F, 1'b1);
    wait_pos(33); check_output("en_d1_dp", 4'b1101, 7'h30, 1'b0);
    wait_pos(49); check_output("en_d0", 4'hF, 7'h7F, 1'b1);
    wait_pos(1);  check_output("en_d3", 4'b0111, 7'h79, 1'b1);

    // Randomized inputs changing at arbitrary points in the frame
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 15) == 0) apply_stimulus();
    end

    // Asynchronous reset in the middle of the digit-1 slot
    data = 16'h1234; dp = 4'h0; digit_en = 4'hF; lz_blank = 1'b0; brightness = 2'd3;
    wait_pos(0);
    wait_pos(40);
    #2 rst_n = 1'b0;
    #1;
    check_output("async_reset", 4'hF, 7'h7F, 1'b1);
    check_val("async_reset.frame_start", 16'(frame_start), 16'h0);
    data = 16'hABCD;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("restart.frame_start", 16'(frame_start), 16'h1);
    @(negedge clk);
    check_output("restart_d3", 4'b0111, 7'h08, 1'b1);
    repeat (100) @(negedge clk);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
